// File: rtl/rs_multi_cdb_if.sv
// Dispatch, wakeup, flush and issue bundle for rs_multi_cdb.
// master = dispatch/ROB/FU side, slave = reservation station.
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

interface rs_multi_cdb_if #(
    parameter int unsigned RS_DEPTH  = 8,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned ROB_IDX_W = `ROB_IDX_SIZE,
    parameter int unsigned DATA_W    = `GPR_SIZE
);
    localparam int unsigned RS_IDX_W = $clog2(RS_DEPTH) + 1;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned COND_W   = 4;

    logic                        disp_valid;
    logic                        disp_ready;
    logic [OP_W-1:0]             disp_op;
    logic [COND_W-1:0]           disp_cond;
    logic [ROB_IDX_W-1:0]        disp_dst;
    logic                        disp_a_valid;
    logic [DATA_W-1:0]           disp_a_value;
    logic [ROB_IDX_W-1:0]        disp_a_tag;
    logic                        disp_b_valid;
    logic [DATA_W-1:0]           disp_b_value;
    logic [ROB_IDX_W-1:0]        disp_b_tag;
    logic                        disp_uses_nzcv;
    logic                        disp_nzcv_valid;
    logic [3:0]                  disp_nzcv;
    logic [ROB_IDX_W-1:0]        disp_nzcv_tag;
    logic                        disp_set_nzcv;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]   cdb_value;
    logic [NUM_CDB-1:0]          cdb_set_nzcv;
    logic [NUM_CDB*4-1:0]        cdb_nzcv;
    logic [ROB_IDX_W-1:0]        rob_head;
    logic                        flush;
    logic [ROB_IDX_W-1:0]        flush_tag;
    logic                        fu_ready;
    logic                        issue_valid;
    logic [OP_W-1:0]             issue_op;
    logic [COND_W-1:0]           issue_cond;
    logic [ROB_IDX_W-1:0]        issue_dst;
    logic [DATA_W-1:0]           issue_a;
    logic [DATA_W-1:0]           issue_b;
    logic [3:0]                  issue_nzcv;
    logic                        issue_set_nzcv;
    logic [RS_IDX_W-1:0]         occupancy;

    modport master (
        output disp_valid, disp_op, disp_cond, disp_dst,
               disp_a_valid, disp_a_value, disp_a_tag,
               disp_b_valid, disp_b_value, disp_b_tag,
               disp_uses_nzcv, disp_nzcv_valid, disp_nzcv, disp_nzcv_tag, disp_set_nzcv,
               cdb_valid, cdb_tag, cdb_value, cdb_set_nzcv, cdb_nzcv,
               rob_head, flush, flush_tag, fu_ready,
        input  disp_ready, issue_valid, issue_op, issue_cond, issue_dst,
               issue_a, issue_b, issue_nzcv, issue_set_nzcv, occupancy
    );

    modport slave (
        input  disp_valid, disp_op, disp_cond, disp_dst,
               disp_a_valid, disp_a_value, disp_a_tag,
               disp_b_valid, disp_b_value, disp_b_tag,
               disp_uses_nzcv, disp_nzcv_valid, disp_nzcv, disp_nzcv_tag, disp_set_nzcv,
               cdb_valid, cdb_tag, cdb_value, cdb_set_nzcv, cdb_nzcv,
               rob_head, flush, flush_tag, fu_ready,
        output disp_ready, issue_valid, issue_op, issue_cond, issue_dst,
               issue_a, issue_b, issue_nzcv, issue_set_nzcv, occupancy
    );
endinterface

// File: rtl/rs_multi_cdb.sv
// Parametrised reservation station with NUM_CDB wakeup ports, age-based flush and single issue.
// RS_OLDEST_FIRST_EN: issue picks the oldest ready entry instead of the lowest index.
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4
`endif
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif

module rs_multi_cdb #(
    parameter int unsigned RS_DEPTH  = 8,
    parameter int unsigned RS_IDX_W  = $clog2(RS_DEPTH) + 1,
    parameter int unsigned NUM_CDB   = 2,
    parameter int unsigned ROB_IDX_W = `ROB_IDX_SIZE,
    parameter int unsigned DATA_W    = `GPR_SIZE
) (
    input logic           clk,
    input logic           rst,
    rs_multi_cdb_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(RS_DEPTH);
    localparam int unsigned OP_W  = 4;
    localparam logic [OP_W-1:0] OP_LDUR = 4'd8;
    localparam logic [OP_W-1:0] OP_STUR = 4'd9;

    typedef logic [ROB_IDX_W-1:0] tag_t;
    typedef logic [DATA_W-1:0]    data_t;

    logic [RS_DEPTH-1:0] valid, a_v, b_v, uses_nzcv, nzcv_v, set_nzcv;
    logic [OP_W-1:0]     op       [RS_DEPTH];
    logic [3:0]          cond     [RS_DEPTH];
    logic [3:0]          nzcv     [RS_DEPTH];
    tag_t                dst      [RS_DEPTH];
    tag_t                a_tag    [RS_DEPTH];
    tag_t                b_tag    [RS_DEPTH];
    tag_t                nzcv_tag [RS_DEPTH];
    data_t               a        [RS_DEPTH];
    data_t               b        [RS_DEPTH];
    logic [RS_IDX_W-1:0] occ;
    logic [SEL_W-1:0]    sel_q;

    logic [NUM_CDB-1:0]           cdb_valid, cdb_set_nzcv;
    logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]    cdb_value;
    logic [NUM_CDB*4-1:0]         cdb_nzcv;
    tag_t                         rob_head;

    assign cdb_valid    = bus.cdb_valid;
    assign cdb_set_nzcv = bus.cdb_set_nzcv;
    assign cdb_tag      = bus.cdb_tag;
    assign cdb_value    = bus.cdb_value;
    assign cdb_nzcv     = bus.cdb_nzcv;
    assign rob_head     = bus.rob_head;

    function automatic tag_t age_of(input tag_t t);
        return t - rob_head;
    endfunction

    // {hit, value}; iterate high to low so the lowest-numbered port wins duplicates
    function automatic logic [DATA_W:0] wake_data(input tag_t t);
        logic [DATA_W:0] r;
        r = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--)
            if (cdb_valid[p] && cdb_tag[p*ROB_IDX_W +: ROB_IDX_W] == t)
                r = {1'b1, cdb_value[p*DATA_W +: DATA_W]};
        return r;
    endfunction

    function automatic logic [4:0] wake_flags(input tag_t t);
        logic [4:0] r;
        r = '0;
        for (int p = NUM_CDB - 1; p >= 0; p--)
            if (cdb_valid[p] && cdb_set_nzcv[p] && cdb_tag[p*ROB_IDX_W +: ROB_IDX_W] == t)
                r = {1'b1, cdb_nzcv[p*4 +: 4]};
        return r;
    endfunction

    // LDUR/STUR keep their immediate in A until the base register arrives
    function automatic data_t a_capture(input logic [OP_W-1:0] o, input data_t imm, input data_t v);
        return (o == OP_LDUR || o == OP_STUR) ? imm + v : v;
    endfunction

    logic [DATA_W:0]     aw [RS_DEPTH];
    logic [DATA_W:0]     bw [RS_DEPTH];
    logic [4:0]          fw [RS_DEPTH];
    logic [DATA_W:0]     daw, dbw;
    logic [4:0]          dfw;
    logic [RS_DEPTH-1:0] ready, squash;
    logic [RS_IDX_W-1:0] n_squash;
    logic [SEL_W-1:0]    free_idx, sel_c, sel_eff;
    logic                any_ready, disp_ok, disp_acc, fire;
    tag_t                flush_age;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            aw[i] = wake_data(a_tag[i]);
            bw[i] = wake_data(b_tag[i]);
            fw[i] = wake_flags(nzcv_tag[i]);
        end
        daw = wake_data(bus.disp_a_tag);
        dbw = wake_data(bus.disp_b_tag);
        dfw = wake_flags(bus.disp_nzcv_tag);
    end

    // ready, flush victims and free slot from registered state
    always_comb begin
        flush_age = age_of(bus.flush_tag);
        n_squash  = '0;
        free_idx  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            ready[i]  = valid[i] & a_v[i] & b_v[i] & (~uses_nzcv[i] | nzcv_v[i]);
            squash[i] = bus.flush & valid[i] & (age_of(dst[i]) > flush_age);
            n_squash  = n_squash + RS_IDX_W'(squash[i]);
        end
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (!valid[i]) free_idx = SEL_W'(i);
    end

`ifdef RS_OLDEST_FIRST_EN
    tag_t best_age;
`endif

    always_comb begin
        any_ready = 1'b0;
        sel_c     = '0;
`ifdef RS_OLDEST_FIRST_EN
        best_age = '1;
        for (int i = 0; i < RS_DEPTH; i++)
            if (ready[i] && (!any_ready || age_of(dst[i]) < best_age)) begin
                any_ready = 1'b1;
                sel_c     = SEL_W'(i);
                best_age  = age_of(dst[i]);
            end
`else
        for (int i = RS_DEPTH - 1; i >= 0; i--)
            if (ready[i]) begin
                any_ready = 1'b1;
                sel_c     = SEL_W'(i);
            end
`endif
    end

    assign bus.disp_ready = occ < RS_IDX_W'(RS_DEPTH);
    assign disp_ok        = ~(bus.flush & (age_of(bus.disp_dst) > flush_age));
    assign disp_acc       = bus.disp_valid & bus.disp_ready & disp_ok;
    assign fire           = any_ready & bus.fu_ready & ~squash[sel_c];
    assign sel_eff        = any_ready ? sel_c : sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            occ   <= '0;
            sel_q <= '0;
        end else begin
            occ <= occ + RS_IDX_W'(disp_acc) - RS_IDX_W'(fire) - n_squash;
            if (any_ready) sel_q <= sel_c;
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (squash[i] || (fire && sel_c == SEL_W'(i))) valid[i] <= 1'b0;
                else if (disp_acc && free_idx == SEL_W'(i)) valid[i] <= 1'b1;
            end
        end
    end

    // Payload: dispatch load with same-cycle wakeup, or wakeup of pending operands
    always_ff @(posedge clk) begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (disp_acc && free_idx == SEL_W'(i)) begin
                op[i]        <= bus.disp_op;
                cond[i]      <= bus.disp_cond;
                dst[i]       <= bus.disp_dst;
                a_tag[i]     <= bus.disp_a_tag;
                b_tag[i]     <= bus.disp_b_tag;
                nzcv_tag[i]  <= bus.disp_nzcv_tag;
                uses_nzcv[i] <= bus.disp_uses_nzcv;
                set_nzcv[i]  <= bus.disp_set_nzcv;
                a_v[i]       <= bus.disp_a_valid | daw[DATA_W];
                a[i]         <= (!bus.disp_a_valid && daw[DATA_W])
                                ? a_capture(bus.disp_op, bus.disp_a_value, daw[DATA_W-1:0])
                                : bus.disp_a_value;
                b_v[i]       <= bus.disp_b_valid | dbw[DATA_W];
                b[i]         <= (!bus.disp_b_valid && dbw[DATA_W]) ? dbw[DATA_W-1:0] : bus.disp_b_value;
                nzcv_v[i]    <= bus.disp_nzcv_valid | dfw[4];
                nzcv[i]      <= (!bus.disp_nzcv_valid && dfw[4]) ? dfw[3:0] : bus.disp_nzcv;
            end else if (valid[i]) begin
                if (!a_v[i] && aw[i][DATA_W]) begin
                    a_v[i] <= 1'b1;
                    a[i]   <= a_capture(op[i], a[i], aw[i][DATA_W-1:0]);
                end
                if (!b_v[i] && bw[i][DATA_W]) begin
                    b_v[i] <= 1'b1;
                    b[i]   <= bw[i][DATA_W-1:0];
                end
                if (!nzcv_v[i] && fw[i][4]) begin
                    nzcv_v[i] <= 1'b1;
                    nzcv[i]   <= fw[i][3:0];
                end
            end
        end
    end

    assign bus.issue_valid    = any_ready;
    assign bus.issue_op       = op[sel_eff];
    assign bus.issue_cond     = cond[sel_eff];
    assign bus.issue_dst      = dst[sel_eff];
    assign bus.issue_a        = a[sel_eff];
    assign bus.issue_b        = b[sel_eff];
    assign bus.issue_nzcv     = nzcv[sel_eff];
    assign bus.issue_set_nzcv = set_nzcv[sel_eff];
    assign bus.occupancy      = occ;
endmodule

// File: tb/tb_rs_multi_cdb.sv
// Self-checking bench for rs_multi_cdb: vector table for dispatch/wakeup, hand sequences
// for full, wrap-around flush, flush-vs-issue and issue ordering; scoreboard on issue.
module tb_rs_multi_cdb;
    localparam int unsigned RS_DEPTH  = 8;
    localparam int unsigned NUM_CDB   = 2;
    localparam int unsigned ROB_IDX_W = 4;
    localparam int unsigned DATA_W    = 64;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_LDUR = 4'd8;
    localparam logic [3:0] OP_STUR = 4'd9;
    localparam int NV = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_multi_cdb_if #(.RS_DEPTH(RS_DEPTH), .NUM_CDB(NUM_CDB), .ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W)) bus ();
    rs_multi_cdb #(.RS_DEPTH(RS_DEPTH), .NUM_CDB(NUM_CDB), .ROB_IDX_W(ROB_IDX_W), .DATA_W(DATA_W))
        dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0]  dst;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  nzcv;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic        a_v;
        logic [63:0] a_val;
        logic        b_v;
        logic [63:0] b_val;
        logic        nz_p;
        logic [3:0]  tag;
        int          port;   // 2 = both ports with the same tag
        int          when;   // 0 none, 1 with dispatch, 2 cycle after
        logic [63:0] cval;
        logic [3:0]  cnz;
        logic [3:0]  dst;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [3:0]  enz;
    } vec_t;

    exp_t sb[$];
    vec_t vt[NV];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] age(input logic [3:0] t);
        return t - bus.rob_head;
    endfunction

    // Issue monitor: a handshake completes unless the selected entry is flushed the same cycle
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.issue_valid && bus.fu_ready &&
            !(bus.flush && age(bus.issue_dst) > age(bus.flush_tag))) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_issue: got dst %0d expected no issue", bus.issue_dst);
            end else begin
                e = sb.pop_front();
                check("issue", {bus.issue_dst, bus.issue_a, bus.issue_b, bus.issue_nzcv}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;       bus.disp_op = '0;          bus.disp_cond = '0;
        bus.disp_dst = '0;           bus.disp_a_valid = 1'b0;   bus.disp_a_value = '0;
        bus.disp_a_tag = '0;         bus.disp_b_valid = 1'b0;   bus.disp_b_value = '0;
        bus.disp_b_tag = '0;         bus.disp_uses_nzcv = 1'b0; bus.disp_nzcv_valid = 1'b1;
        bus.disp_nzcv = '0;          bus.disp_nzcv_tag = '0;    bus.disp_set_nzcv = 1'b0;
        bus.cdb_valid = '0;          bus.cdb_tag = '0;          bus.cdb_value = '0;
        bus.cdb_set_nzcv = '0;       bus.cdb_nzcv = '0;         bus.rob_head = '0;
        bus.flush = 1'b0;            bus.flush_tag = '0;        bus.fu_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [3:0] dst,
                            input logic av, input logic [63:0] aval, input logic [3:0] atag,
                            input logic bv, input logic [63:0] bval, input logic [3:0] btag);
        bus.disp_op = op;       bus.disp_dst = dst;
        bus.disp_a_valid = av;  bus.disp_a_value = aval; bus.disp_a_tag = atag;
        bus.disp_b_valid = bv;  bus.disp_b_value = bval; bus.disp_b_tag = btag;
        bus.disp_uses_nzcv = 1'b0; bus.disp_nzcv_valid = 1'b1;
        bus.disp_valid = 1'b1;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic [3:0] dst,
                            input logic av, input logic [63:0] aval, input logic [3:0] atag,
                            input logic bv, input logic [63:0] bval, input logic [3:0] btag);
        set_disp(op, dst, av, aval, atag, bv, bval, btag);
        tick();
        bus.disp_valid = 1'b0;
    endtask

    task automatic cdb_set(input int p, input logic [3:0] tag, input logic [63:0] val,
                           input logic snz, input logic [3:0] nz);
        bus.cdb_valid[p]        = 1'b1;
        bus.cdb_tag[p*4 +: 4]   = tag;
        bus.cdb_value[p*64 +: 64] = val;
        bus.cdb_set_nzcv[p]     = snz;
        bus.cdb_nzcv[p*4 +: 4]  = nz;
    endtask

    task automatic cdb_clear();
        bus.cdb_valid = '0;
        bus.cdb_set_nzcv = '0;
    endtask

    task automatic cdb_vec(input vec_t v);
        if (v.port == 2) begin
            cdb_set(0, v.tag, v.cval, v.nz_p, v.cnz);
            cdb_set(1, v.tag, v.cval + 64'd1000, v.nz_p, v.cnz);
        end else begin
            cdb_set(v.port, v.tag, v.cval, v.nz_p, v.cnz);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending issues expected 0", sb.size());
            sb.delete();
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{OP_ADD,  1'b1, 64'd3,  1'b1, 64'd4, 1'b0, 4'd0,  0, 0, 64'd0,     4'd0,    4'd1, 64'd3,   64'd4,     4'd0};
        vt[1] = '{OP_ADD,  1'b0, 64'd0,  1'b1, 64'd4, 1'b0, 4'd5,  0, 2, 64'd9,     4'd0,    4'd2, 64'd9,   64'd4,     4'd0};
        vt[2] = '{OP_ADD,  1'b0, 64'd0,  1'b1, 64'd4, 1'b0, 4'd5,  1, 1, 64'd9,     4'd0,    4'd3, 64'd9,   64'd4,     4'd0};
        vt[3] = '{OP_LDUR, 1'b0, 64'd8,  1'b1, 64'd0, 1'b0, 4'd3,  0, 2, 64'd100,   4'd0,    4'd4, 64'd108, 64'd0,     4'd0};
        vt[4] = '{OP_STUR, 1'b0, 64'd16, 1'b1, 64'd7, 1'b0, 4'd7,  1, 1, 64'h20,    4'd0,    4'd5, 64'h30,  64'd7,     4'd0};
        vt[5] = '{OP_ADD,  1'b0, 64'd0,  1'b0, 64'd0, 1'b0, 4'd6,  2, 2, 64'd11,    4'd0,    4'd6, 64'd11,  64'd11,    4'd0};
        vt[6] = '{OP_ADD,  1'b1, 64'd1,  1'b0, 64'd0, 1'b0, 4'd12, 1, 2, 64'hdead,  4'd0,    4'd7, 64'd1,   64'hdead,  4'd0};
        vt[7] = '{OP_ADD,  1'b1, 64'd2,  1'b1, 64'd3, 1'b1, 4'd4,  0, 2, 64'd0,     4'b1010, 4'd8, 64'd2,   64'd3,     4'b1010};
        vt[8] = '{OP_ADD,  1'b1, 64'd5,  1'b1, 64'd6, 1'b1, 4'd4,  1, 1, 64'd0,     4'b0110, 4'd9, 64'd5,   64'd6,     4'b0110};

        do_reset();
        check("rst_occupancy", bus.occupancy, 0);
        check("rst_disp_ready", bus.disp_ready, 1);
        check("rst_issue_valid", bus.issue_valid, 0);

        // Single-instruction dispatch/wakeup vectors
        for (int k = 0; k < NV; k++) begin
            vec_t v;
            v = vt[k];
            set_disp(v.op, v.dst, v.a_v, v.a_val, v.a_v ? 4'd0 : v.tag,
                     v.b_v, v.b_val, v.b_v ? 4'd0 : v.tag);
            bus.disp_uses_nzcv  = v.nz_p;
            bus.disp_nzcv_valid = !v.nz_p;
            bus.disp_nzcv_tag   = v.tag;
            bus.fu_ready        = 1'b1;
            if (v.when == 1) cdb_vec(v);
            tick();
            bus.disp_valid = 1'b0;
            cdb_clear();
            sb.push_back('{v.dst, v.ea, v.eb, v.enz});
            if (v.when != 2) begin
                check("ready_next_cycle", bus.issue_valid, 1);
            end else begin
                check("wait_for_wakeup", bus.issue_valid, 0);
                cdb_vec(v);
                tick();
                cdb_clear();
            end
            drain();
            check("occupancy_drained", bus.occupancy, 0);
        end

        // Full station blocks dispatch; one free re-opens it
        do_reset();
        for (int i = 0; i < RS_DEPTH; i++)
            dispatch(OP_ADD, 4'(i), 1'b0, 64'd0, 4'(8 + i), 1'b1, 64'd0, 4'd0);
        check("full_occupancy", bus.occupancy, RS_DEPTH);
        check("full_disp_ready", bus.disp_ready, 0);
        dispatch(OP_ADD, 4'd9, 1'b1, 64'd42, 4'd0, 1'b1, 64'd43, 4'd0);
        check("full_drop_occupancy", bus.occupancy, RS_DEPTH);
        check("full_drop_no_issue", bus.issue_valid, 0);
        cdb_set(0, 4'd11, 64'd55, 1'b0, 4'd0);
        bus.fu_ready = 1'b1;
        sb.push_back('{4'd3, 64'd55, 64'd0, 4'd0});
        tick();
        cdb_clear();
        check("full_issue_valid", bus.issue_valid, 1);
        check("full_ready_during_issue", bus.disp_ready, 0);
        tick();
        bus.fu_ready = 1'b0;
        check("full_ready_after_free", bus.disp_ready, 1);
        check("full_occupancy_after_free", bus.occupancy, RS_DEPTH - 1);
        drain();

        // ROB wrap: head=14, flush at 15 kills dst 0/1 and a same-cycle younger dispatch
        do_reset();
        bus.rob_head = 4'd14;
        dispatch(OP_ADD, 4'd14, 1'b0, 64'd0, 4'd9, 1'b1, 64'd0, 4'd0);
        dispatch(OP_ADD, 4'd15, 1'b0, 64'd0, 4'd9, 1'b1, 64'd1, 4'd0);
        dispatch(OP_ADD, 4'd0,  1'b0, 64'd0, 4'd9, 1'b1, 64'd2, 4'd0);
        dispatch(OP_ADD, 4'd1,  1'b0, 64'd0, 4'd9, 1'b1, 64'd3, 4'd0);
        check("wrap_occupancy", bus.occupancy, 4);
        set_disp(OP_ADD, 4'd2, 1'b1, 64'd1, 4'd0, 1'b1, 64'd1, 4'd0);
        bus.flush = 1'b1;
        bus.flush_tag = 4'd15;
        tick();
        bus.flush = 1'b0;
        bus.disp_valid = 1'b0;
        check("wrap_flush_occupancy", bus.occupancy, 2);
        check("wrap_flush_dropped_disp", bus.issue_valid, 0);
        sb.push_back('{4'd14, 64'd77, 64'd0, 4'd0});
        sb.push_back('{4'd15, 64'd77, 64'd1, 4'd0});
        cdb_set(1, 4'd9, 64'd77, 1'b0, 4'd0);
        bus.fu_ready = 1'b1;
        tick();
        cdb_clear();
        drain();
        bus.fu_ready = 1'b0;
        check("wrap_final_occupancy", bus.occupancy, 0);

        // Flush vs issue in the same cycle
        do_reset();
        dispatch(OP_ADD, 4'd3, 1'b1, 64'd5, 4'd0, 1'b1, 64'd6, 4'd0);
        dispatch(OP_ADD, 4'd1, 1'b0, 64'd0, 4'd9, 1'b1, 64'd0, 4'd0);
        bus.flush = 1'b1;
        bus.flush_tag = 4'd1;
        bus.fu_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.fu_ready = 1'b0;
        check("squashed_issue_occupancy", bus.occupancy, 1);
        check("squashed_issue_valid", bus.issue_valid, 0);
        dispatch(OP_ADD, 4'd2, 1'b1, 64'd7, 4'd0, 1'b1, 64'd8, 4'd0);
        sb.push_back('{4'd2, 64'd7, 64'd8, 4'd0});
        bus.flush = 1'b1;
        bus.flush_tag = 4'd2;
        bus.fu_ready = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.fu_ready = 1'b0;
        check("survivor_issue_occupancy", bus.occupancy, 1);
        drain();

        // Issue ordering between idx0 (dst 6) and idx3 (dst 2)
        do_reset();
        dispatch(OP_ADD, 4'd6, 1'b1, 64'd60, 4'd0, 1'b1, 64'd61, 4'd0);
        dispatch(OP_ADD, 4'd4, 1'b0, 64'd0, 4'd13, 1'b1, 64'd0, 4'd0);
        dispatch(OP_ADD, 4'd5, 1'b0, 64'd0, 4'd13, 1'b1, 64'd0, 4'd0);
        dispatch(OP_ADD, 4'd2, 1'b1, 64'd20, 4'd0, 1'b1, 64'd21, 4'd0);
`ifdef RS_OLDEST_FIRST_EN
        sb.push_back('{4'd2, 64'd20, 64'd21, 4'd0});
        sb.push_back('{4'd6, 64'd60, 64'd61, 4'd0});
`else
        sb.push_back('{4'd6, 64'd60, 64'd61, 4'd0});
        sb.push_back('{4'd2, 64'd20, 64'd21, 4'd0});
`endif
        bus.fu_ready = 1'b1;
        drain();
        bus.fu_ready = 1'b0;
        check("order_occupancy", bus.occupancy, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
